sseg_scan_driver: RTL and testbench



---
 rtl/sseg_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with per-frame input snapshot,
// leading-zero blanking and a blank window at the start of every digit slot.

module sseg_lane #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       dp_req,
  input  logic       hit,
  input  logic       window,
  input  logic       lzb,
  input  logic       upper_zero,
  output logic       on,
  output logic [6:0] seg,
  output logic       dpn
);
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  logic lz_blank;

  // The rightmost digit always shows, so a zero value still displays "0".
  assign lz_blank = lzb & upper_zero & ~IS_LSD;
  assign on       = hit & window & en & ~lz_blank;
  assign seg      = on ? decode(nib) : 7'h7F;
  assign dpn      = on ? ~dp_req : 1'b1;
endmodule

module sseg_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_DIV          = 100000,
  parameter int BLANK_CYCLES     = 1000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(CLK_DIV)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [SEL_W-1:0]        digit_sel,
  output logic                    frame_tick
);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]                cnt;
  logic [SEL_W-1:0]                sel;
  logic [NUM_DIGITS-1:0][3:0]      sh_digits, cur_digits;
  logic [NUM_DIGITS-1:0]           sh_dp, cur_dp;
  logic [NUM_DIGITS-1:0]           sh_en, cur_en;
  logic                            sh_lzb, cur_lzb;

  logic                            frame_start, last_cnt, last_sel, window;
  logic [NUM_DIGITS-1:0]           hit, on, upper_zero;
  logic [NUM_DIGITS-1:0][6:0]      lane_seg;
  logic [NUM_DIGITS-1:0]           lane_dp;
  logic [6:0]                      seg_n;
  logic                            dp_n;

  assign frame_start = (cnt == '0) && (sel == '0);
  assign last_cnt    = (cnt == CNT_W'(CLK_DIV - 1));
  assign last_sel    = (sel == SEL_W'(NUM_DIGITS - 1));

  // The frame-start cycle already shows the freshly captured inputs.
  assign cur_digits = frame_start ? digits   : sh_digits;
  assign cur_dp     = frame_start ? dp_in    : sh_dp;
  assign cur_en     = frame_start ? digit_en : sh_en;
  assign cur_lzb    = frame_start ? lzb_en   : sh_lzb;

  generate
    if (BLANK_CYCLES == 0) begin : g_nowin
      assign window = 1'b1;
    end else begin : g_win
      assign window = (cnt >= CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  // upper_zero[k]: nibbles k..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic z;
    z          = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z             = z & (cur_digits[k] == 4'h0);
      upper_zero[k] = z;
    end
  end

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
      assign hit[k] = (sel == SEL_W'(k));
      sseg_lane #(.IS_LSD(k == 0)) u_lane (
        .nib        (cur_digits[k]),
        .en         (cur_en[k]),
        .dp_req     (cur_dp[k]),
        .hit        (hit[k]),
        .window     (window),
        .lzb        (cur_lzb),
        .upper_zero (upper_zero[k]),
        .on         (on[k]),
        .seg        (lane_seg[k]),
        .dpn        (lane_dp[k])
      );
    end
  endgenerate

  // Inactive lanes drive all-ones, so an AND merges the active-low cathodes.
  always_comb begin
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_n = seg_n & lane_seg[k];
      dp_n  = dp_n & lane_dp[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sel       <= '0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      sh_lzb    <= 1'b0;
    end else begin
      cnt <= last_cnt ? '0 : cnt + 1'b1;
      if (last_cnt) sel <= last_sel ? '0 : sel + 1'b1;
      if (frame_start) begin
        sh_digits <= digits;
        sh_dp     <= dp_in;
        sh_en     <= digit_en;
        sh_lzb    <= lzb_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anode      <= ANODE_OFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      anode      <= ANODE_ACTIVE_LOW ? ~on : on;
      seg        <= seg_n;
      dp         <= dp_n;
      digit_sel  <= sel;
      frame_tick <= frame_start;
    end
  end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomised and directed bench for sseg_scan_driver against a time-indexed display model.

module tb_sseg_scan_driver;
  localparam int N  = 4;
  localparam int CD = 4;
  localparam int BC = 1;
  localparam int FRAME = N * CD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in, digit_en;
  logic        lzb_en;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  sseg_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BC), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .digit_en(digit_en),
    .lzb_en(lzb_en), .anode(anode), .seg(seg), .dp(dp), .digit_sel(digit_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model snapshot and the expected outputs after the most recent edge.
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_en;
  logic        m_lzb;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [1:0]  e_sel;
  logic        e_ft;

  // Edge number t since reset release: slot = (t/CD)%N, position in slot = t%CD.
  task automatic advance();
    int slot, pos;
    bit lit;
    @(posedge clk);
    if (t % FRAME == 0) begin
      m_digits = digits; m_dp = dp_in; m_en = digit_en; m_lzb = lzb_en;
    end
    slot = (t / CD) % N;
    pos  = t % CD;
    lit  = (pos >= BC) && m_en[slot] &&
           !(m_lzb && slot != 0 && (m_digits >> (4 * slot)) == 16'h0);
    e_anode = lit ? ~(4'b0001 << slot) : 4'b1111;
    e_seg   = lit ? seg_tab[(m_digits >> (4 * slot)) & 16'hF] : 7'h7F;
    e_dp    = lit ? ~m_dp[slot] : 1'b1;
    e_sel   = 2'(slot);
    e_ft    = (t % FRAME == 0);
    t++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    digits = 16'h12AF; dp_in = 4'h0; digit_en = 4'hF; lzb_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if ({anode, seg, dp, digit_sel, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got an=%b seg=%h dp=%b sel=%0d ft=%b", i, anode, seg, dp, digit_sel, frame_tick);
      end
      total++;
    end
    reset = 1'b0;
    t = 0;
    advance();
    if (frame_tick !== 1'b1 || anode !== 4'b1111) begin
      bad++;
      $display("FAIL reset_first_edge got ft=%b an=%b exp ft=1 an=1111", frame_tick, anode);
    end
    total++;
    for (int i = 0; i < 3; i++) begin
      advance();
      if (anode !== 4'b1110 || seg !== 7'h0E) begin
        bad++;
        $display("FAIL reset_slot0 cyc=%0d got an=%b seg=%h exp an=1110 seg=0e", i, anode, seg);
      end
      total++;
    end
  endtask

  task automatic test_basic();
    int last_tick;
    last_tick = -1;
    digits = 16'h12AF; dp_in = 4'h0; digit_en = 4'hF; lzb_en = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      advance();
      if ({anode, seg, dp, digit_sel, frame_tick} !== {e_anode, e_seg, e_dp, e_sel, e_ft}) begin
        bad++;
        $display("FAIL basic t=%0d got an=%b seg=%h dp=%b sel=%0d ft=%b exp an=%b seg=%h dp=%b sel=%0d ft=%b",
                 t - 1, anode, seg, dp, digit_sel, frame_tick, e_anode, e_seg, e_dp, e_sel, e_ft);
      end
      total++;
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          if (t - last_tick !== FRAME) begin
            bad++;
            $display("FAIL tick_period got %0d exp %0d", t - last_tick, FRAME);
          end
          total++;
        end
        last_tick = t;
      end
    end
  endtask

  task automatic test_lzb();
    digits = 16'h0030; digit_en = 4'hF; dp_in = 4'h0; lzb_en = 1'b1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      advance();
      if ({anode, seg, dp, digit_sel, frame_tick} !== {e_anode, e_seg, e_dp, e_sel, e_ft}) begin
        bad++;
        $display("FAIL lzb_0030 t=%0d got an=%b seg=%h exp an=%b seg=%h", t - 1, anode, seg, e_anode, e_seg);
      end
      total++;
    end
    digits = 16'h0000;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      advance();
      if ({anode, seg, dp, digit_sel, frame_tick} !== {e_anode, e_seg, e_dp, e_sel, e_ft}) begin
        bad++;
        $display("FAIL lzb_0000 t=%0d got an=%b seg=%h exp an=%b seg=%h", t - 1, anode, seg, e_anode, e_seg);
      end
      total++;
    end
  endtask

  task automatic test_en_dp();
    digits = 16'h5A3C; digit_en = 4'b0101; dp_in = 4'b0100; lzb_en = 1'b0;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      advance();
      if ({anode, seg, dp, digit_sel, frame_tick} !== {e_anode, e_seg, e_dp, e_sel, e_ft}) begin
        bad++;
        $display("FAIL en_dp t=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                 t - 1, anode, seg, dp, e_anode, e_seg, e_dp);
      end
      total++;
    end
  endtask

  task automatic test_midframe();
    int frames_seen;
    digits = 16'h1234; digit_en = 4'hF; dp_in = 4'h0; lzb_en = 1'b0;
    while (t % FRAME != 0) advance();
    while ((t % FRAME) / CD != 2) advance();
    digits = 16'h9876; dp_in = 4'hF;
    frames_seen = 0;
    while (frames_seen < 2) begin
      advance();
      if (e_ft) frames_seen++;
      if ({anode, seg, dp, digit_sel, frame_tick} !== {e_anode, e_seg, e_dp, e_sel, e_ft}) begin
        bad++;
        $display("FAIL midframe t=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                 t - 1, anode, seg, dp, e_anode, e_seg, e_dp);
      end
      total++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        digits   = 16'($urandom);
        if ($urandom_range(0, 2) == 0) digits = digits & 16'h00FF;
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
        lzb_en   = 1'($urandom);
      end
      advance();
      if ({anode, seg, dp, digit_sel, frame_tick} !== {e_anode, e_seg, e_dp, e_sel, e_ft}) begin
        bad++;
        $display("FAIL random t=%0d got an=%b seg=%h dp=%b sel=%0d ft=%b exp an=%b seg=%h dp=%b sel=%0d ft=%b",
                 t - 1, anode, seg, dp, digit_sel, frame_tick, e_anode, e_seg, e_dp, e_sel, e_ft);
      end
      total++;
    end
  endtask

  task automatic test_reset_mid();
    digits = 16'hBEEF; digit_en = 4'hF; dp_in = 4'h2; lzb_en = 1'b0;
    while (t % FRAME != 10) advance();
    reset = 1'b1;
    @(posedge clk); #1;
    if ({anode, seg, dp, digit_sel, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got an=%b seg=%h dp=%b sel=%0d ft=%b", anode, seg, dp, digit_sel, frame_tick);
    end
    total++;
    reset = 1'b0;
    t = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      advance();
      if ({anode, seg, dp, digit_sel, frame_tick} !== {e_anode, e_seg, e_dp, e_sel, e_ft}) begin
        bad++;
        $display("FAIL reset_restart t=%0d got an=%b seg=%h dp=%b sel=%0d ft=%b exp an=%b seg=%h dp=%b sel=%0d ft=%b",
                 t - 1, anode, seg, dp, digit_sel, frame_tick, e_anode, e_seg, e_dp, e_sel, e_ft);
      end
      total++;
    end
  endtask

  initial begin
    t = 0;
    test_reset();
    test_basic();
    test_lzb();
    test_en_dp();
    test_midframe();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
